// File: rtl/tl_pkg.sv
// Shared encodings and defaults for the traffic-light interval timer.
package tl_pkg;

    // Duration select driven by the traffic-light FSM.
    localparam logic [1:0] INT_BASE = 2'b00;
    localparam logic [1:0] INT_EXT  = 2'b01;
    localparam logic [1:0] INT_YEL  = 2'b10;
    localparam logic [1:0] INT_DBL  = 2'b11;

    // Parameter-register write target.
    localparam logic [1:0] SEL_BASE = 2'b00;
    localparam logic [1:0] SEL_EXT  = 2'b01;
    localparam logic [1:0] SEL_YEL  = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

    // Default durations in seconds.
    localparam int DEF_BASE = 6;
    localparam int DEF_EXT  = 3;
    localparam int DEF_YEL  = 2;

    // Countdown controller states.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        EXPIRE = 2'b10
    } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock into a one-cycle tick every TICK_DIV enabled cycles.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clock,
    input  logic reset_sync,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int              CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]   LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // Count 0..TICK_DIV-1 while enabled; clr restarts the second from zero.
    always_ff @(posedge clock or posedge reset_sync) begin
        if (reset_sync) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/interval_timer_ctrl.sv
// Programmable interval timer: stores three durations, loads one on start_timer,
// counts it down in 1 s ticks and pulses expired for one cycle at the end.
// Handshake: start_timer is a level sampled every edge (no ready); a high level
// (re)loads the selected duration. expired is a single-cycle registered pulse.
module interval_timer_ctrl #(
    parameter int TICK_DIV = 50_000_000,
    parameter int VAL_W    = 4,
    parameter int DEF_BASE = tl_pkg::DEF_BASE,
    parameter int DEF_EXT  = tl_pkg::DEF_EXT,
    parameter int DEF_YEL  = tl_pkg::DEF_YEL
) (
    input  logic             clock,
    input  logic             reset_sync,
    input  logic             prog_sync,
    input  logic [1:0]       param_sel,
    input  logic [VAL_W-1:0] time_value,
    input  logic [1:0]       interval,
    input  logic             start_timer,
    output logic             expired,
    output logic             busy,
    output logic [VAL_W:0]   remaining
);

    import tl_pkg::*;

    localparam logic [VAL_W-1:0] DEF_BASE_V = VAL_W'(DEF_BASE);
    localparam logic [VAL_W-1:0] DEF_EXT_V  = VAL_W'(DEF_EXT);
    localparam logic [VAL_W-1:0] DEF_YEL_V  = VAL_W'(DEF_YEL);

    logic [VAL_W-1:0] base_r, ext_r, yel_r;
    logic [VAL_W:0]   load_val;
    logic [VAL_W:0]   count, next_count;
    state_t           state, next_state;
    logic             tick, pre_clr, pre_en;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clock      (clock),
        .reset_sync (reset_sync),
        .clr        (pre_clr),
        .en         (pre_en),
        .tick       (tick)
    );

    // Runtime duration writes; a zero value restores the register's default.
    always_ff @(posedge clock or posedge reset_sync) begin
        if (reset_sync) begin
            base_r <= DEF_BASE_V;
            ext_r  <= DEF_EXT_V;
            yel_r  <= DEF_YEL_V;
        end else if (prog_sync) begin
            case (param_sel)
                SEL_BASE: base_r <= (time_value == '0) ? DEF_BASE_V : time_value;
                SEL_EXT:  ext_r  <= (time_value == '0) ? DEF_EXT_V  : time_value;
                SEL_YEL:  yel_r  <= (time_value == '0) ? DEF_YEL_V  : time_value;
                default:  ;
            endcase
        end
    end

    // Load mux reads the registers before any same-edge write lands.
    always_comb begin
        load_val = '0;
        case (interval)
            INT_BASE: load_val = {1'b0, base_r};
            INT_EXT:  load_val = {1'b0, ext_r};
            INT_YEL:  load_val = {1'b0, yel_r};
            default:  load_val = {base_r, 1'b0};
        endcase
    end

    assign pre_en = (state == RUN);

    // Next state and count; a start request reloads from any state and beats a tick.
    always_comb begin
        next_state = state;
        next_count = count;
        pre_clr    = 1'b0;
        if (start_timer) begin
            next_state = RUN;
            next_count = load_val;
            pre_clr    = 1'b1;
        end else begin
            case (state)
                IDLE: ;
                RUN: begin
                    if (tick) begin
                        if (count == (VAL_W+1)'(1)) next_state = EXPIRE;
                        else                        next_count = count - (VAL_W+1)'(1);
                    end
                end
                EXPIRE:  next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // State, count and registered status outputs.
    always_ff @(posedge clock or posedge reset_sync) begin
        if (reset_sync) begin
            state     <= IDLE;
            count     <= '0;
            expired   <= 1'b0;
            busy      <= 1'b0;
            remaining <= '0;
        end else begin
            state     <= next_state;
            count     <= next_count;
            expired   <= (next_state == EXPIRE);
            busy      <= (next_state == RUN);
            remaining <= (next_state == RUN) ? next_count : '0;
        end
    end

endmodule
